// File: rtl/citadel_uart.sv
// citadel_uart: 8N1 MMIO UART with RX holding register, or an RX FIFO when UART_RX_FIFO_EN is defined
module citadel_uart #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        tx,
    input  logic        we,
    input  logic        re,
    output logic [31:0] si,
    input  logic [31:0] so,
    output logic        wa
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} state_t;

    state_t      tx_st, rx_st;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_sh, rx_sh;
    logic        tx_last, rx_done, push, rs;
    logic [1:0]  rx_sync;
    logic        unused_so;

    assign unused_so = ^so[31:8];
    assign tx_last   = tx_cnt == LAST;
    assign rx_done   = rx_st == START ? rx_cnt == HALF : rx_cnt == LAST;
    assign rs        = rx_sync[1];

    // TX: bit timer and frame FSM; tx and wa are registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_st  <= IDLE;
            tx     <= 1'b1;
            wa     <= 1'b0;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
        end else begin
            tx_cnt <= (tx_st == IDLE || tx_last) ? '0 : tx_cnt + 1'b1;
            case (tx_st)
                IDLE: if (we) begin
                    tx_sh <= so[7:0];
                    tx    <= 1'b0;
                    wa    <= 1'b1;
                    tx_st <= START;
                end
                START: if (tx_last) begin
                    tx     <= tx_sh[0];
                    tx_sh  <= tx_sh >> 1;
                    tx_bit <= '0;
                    tx_st  <= DATA;
                end
                DATA: if (tx_last) begin
                    tx     <= tx_bit == 3'd7 ? 1'b1 : tx_sh[0];
                    tx_sh  <= tx_sh >> 1;
                    tx_bit <= tx_bit + 1'b1;
                    tx_st  <= tx_bit == 3'd7 ? STOP : DATA;
                end
                STOP: if (tx_last) begin
                    wa    <= 1'b0;
                    tx_st <= IDLE;
                end
                default: tx_st <= IDLE;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous rx line
    always_ff @(posedge clk) begin
        rx_sync <= rst_n ? {rx_sync[0], rx} : 2'b11;
    end

    // RX: start-bit qualification at half a bit, then centre sampling; push is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_st  <= IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
            push   <= 1'b0;
        end else begin
            push   <= 1'b0;
            rx_cnt <= (rx_st == IDLE || rx_st == WAIT || rx_done) ? '0 : rx_cnt + 1'b1;
            case (rx_st)
                IDLE:  if (!rs) rx_st <= START;
                START: if (rx_done) begin
                    rx_bit <= '0;
                    rx_st  <= rs ? IDLE : DATA;
                end
                DATA: if (rx_done) begin
                    rx_sh  <= {rs, rx_sh[7:1]};
                    rx_bit <= rx_bit + 1'b1;
                    rx_st  <= rx_bit == 3'd7 ? STOP : DATA;
                end
                STOP: if (rx_done) begin
                    push  <= rs;
                    rx_st <= rs ? IDLE : WAIT;
                end
                WAIT:  if (rs) rx_st <= IDLE;
                default: rx_st <= IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam int NW = $clog2(RX_FIFO_DEPTH + 1);
    localparam logic [NW-1:0] FULL = NW'(RX_FIFO_DEPTH);

    logic [7:0]    mem [RX_FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [NW-1:0] cnt;
    logic          pop, wr;

    assign pop = re && cnt != '0;
    assign wr  = push && (cnt != FULL || pop);
    assign si  = cnt == '0 ? 32'hFFFF_FFFF : {24'h0, mem[rp]};

    // FIFO pointers and occupancy; a push on full only lands when a pop frees a slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + NW'(wr) - NW'(pop);
        end
    end

    // FIFO storage array
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= rx_sh;
    end
`else
    localparam int unused_depth = RX_FIFO_DEPTH;

    logic [7:0] hold;
    logic       hv, pop, wr;

    assign pop = re && hv;
    assign wr  = push && (!hv || pop);
    assign si  = hv ? {24'h0, hold} : 32'hFFFF_FFFF;

    // Single holding register; a second byte before re is dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hv   <= 1'b0;
            hold <= '0;
        end else begin
            hv <= wr || (hv && !pop);
            if (wr) hold <= rx_sh;
        end
    end
`endif
endmodule

// File: tb/tb_citadel_uart.sv
// tb_citadel_uart: randomized scoreboard bench for citadel_uart with serial line models
module tb_citadel_uart;
    localparam int CPB = 8;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b1, we = 1'b0, re = 1'b0;
    logic        tx, wa;
    logic [31:0] si, so = '0;
    logic [7:0]  exp_tx[$], exp_rx[$];
    bit          rd_en = 1'b1;
    int          checks = 0, errors = 0;

    citadel_uart #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .we(we), .re(re),
        .si(si), .so(so), .wa(wa)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_tx(input logic [7:0] b, input bit busy_we);
        int n;
        we = 1'b1;
        so = {24'($urandom), b};
        exp_tx.push_back(b);
        @(negedge clk);
        we = 1'b0;
        check("wa_rise", wa, 1);
        n = 0;
        while (wa && n < 200) begin
            n++;
            we = busy_we && n == 20;
            so = busy_we && n == 20 ? 32'h0000_003C : so;
            @(negedge clk);
        end
        we = 1'b0;
        check("wa_busy_len", n, 80);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_bit, input bit real_byte);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        if (real_byte && exp_rx.size() < DEPTH) exp_rx.push_back(b);
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_rx.size() != 0) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check(name, exp_tx.size() + exp_rx.size(), 0);
    endtask

    // TX line monitor: decode each frame at bit centres and score it
    always begin : tx_mon
        logic [9:0] f;
        @(negedge clk);
        if (rst_n && tx === 1'b0) begin
            repeat (3) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                if (i > 0) repeat (CPB) @(negedge clk);
                f[i] = tx;
            end
            check("tx_start_bit", f[0], 0);
            check("tx_stop_bit", f[9], 1);
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %h expected no frame", f[8:1]);
            end else check("tx_data", f[8:1], exp_tx.pop_front());
        end
    end

    // RX monitor: whenever a byte is presented, score it and pop with a one-cycle re
    always begin : rx_mon
        @(negedge clk);
        if (rd_en && rst_n && si !== 32'hFFFF_FFFF) begin
            if (exp_rx.size() == 0) check("rx_unexpected", si, 32'hFFFF_FFFF);
            else check("rx_data", si, {24'h0, exp_rx.pop_front()});
            re = 1'b1;
            @(negedge clk);
            re = 1'b0;
            if (exp_rx.size() == 0) check("rx_empty_after_pop", si, 32'hFFFF_FFFF);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_wa", wa, 0);
        check("reset_si", si, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        @(negedge clk);

        send_tx(8'hA5, 1'b0);
        send_tx(8'hA5, 1'b1);
        check("tx_idle_after", tx, 1);

        rd_en = 1'b0;
        send_rx(8'h5A, 1'b1, 1'b1);
        check("rx_5a_head", si, 32'h0000_005A);
        rd_en = 1'b1;
        wait_empty("rx_5a_drain");
        check("rx_5a_popped", si, 32'hFFFF_FFFF);

        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("rx_glitch", si, 32'hFFFF_FFFF);
        send_rx(8'h11, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("rx_framing", si, 32'hFFFF_FFFF);

        rd_en = 1'b0;
        for (int i = 0; i <= DEPTH; i++) send_rx(8'(i + (DEPTH == 1 ? 1 : 0)), 1'b1, 1'b1);
        check("ovf_head", si, DEPTH == 1 ? 32'h1 : 32'h0);
        rd_en = 1'b1;
        wait_empty("ovf_drain");
        check("ovf_empty", si, 32'hFFFF_FFFF);

        repeat (8) begin
            fork
                send_tx(8'($urandom), 1'b0);
                send_rx(8'($urandom), 1'b1, 1'b1);
            join
        end
        wait_empty("final_drain");
        repeat (20) @(negedge clk);
        check("final_si", si, 32'hFFFF_FFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
